// File: rtl/hack_mem_arbiter.sv
// Arbitrates one single-port data memory between a CPU port (A) and a DMA/screen port (B).
// A has fixed priority, B wins after MAX_WAIT denied cycles, and A can lock the memory for RMW.
module hack_mem_arbiter #(
   parameter int AW       = 14,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic          a_lock,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_in,
   output logic          mem_load,
   input  logic [DW-1:0] mem_out
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   typedef enum logic {IDLE, A_LOCKED} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [WW-1:0] wait_cnt;

   // Grants are gated by rst_n so nothing reaches the memory while reset is held.
   always_comb begin
      a_gnt     = 1'b0;
      b_gnt     = 1'b0;
      state_nxt = state;
      if (rst_n) begin
         if (state == A_LOCKED) begin
            a_gnt = a_req;
            if (!(a_req && a_lock)) state_nxt = IDLE;
         end else begin
            if (b_req && (wait_cnt == WAIT_MAX)) begin
               b_gnt = 1'b1;
            end else begin
               a_gnt = a_req;
               b_gnt = b_req && !a_req;
            end
            if (a_gnt && a_lock) state_nxt = A_LOCKED;
         end
      end
   end

   always_comb begin
      mem_address = '0;
      mem_in      = '0;
      mem_load    = 1'b0;
      if (a_gnt) begin
         mem_address = a_addr;
         mem_in      = a_wdata;
         mem_load    = a_we;
      end else if (b_gnt) begin
         mem_address = b_addr;
         mem_in      = b_wdata;
         mem_load    = b_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (b_gnt || !b_req) wait_cnt <= '0;
         else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rvalid <= 1'b0;
         b_rdata  <= '0;
      end else begin
         a_rvalid <= a_gnt && !a_we;
         b_rvalid <= b_gnt && !b_we;
         if (a_gnt && !a_we) a_rdata <= mem_out;
         if (b_gnt && !b_we) b_rdata <= mem_out;
      end
   end

endmodule
